mux_scan_capture: RTL
=====================

Name: mux_scan_capture

Overview:
- Sequencer that drives the 3-bit select of the 8:1 data-selector stage and reads back its single-bit output F.
- On a start request it steps the select through all eight inputs and waits a programmable settle time per input.
- It samples F for each input and assembles the eight results into a byte: bit i = value seen with select = i.
- The byte is presented on a valid/ready output for the downstream consumer. The block sits directly around the selector: addr feeds it, F returns to it.

Parameters:
- SETTLE_CYC, 1, idle cycles after each addr change before F is sampled (0..15).
- DESCEND, 0, 0 = scan addr 0→7; 1 = scan addr 7→0.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  scan request; honoured only in IDLE.
- f_in  in  1  selector output F.
- addr  out  3  selector address; registered.
- busy  out  1  high from the start-accept edge until the byte handshake completes.
- data_out  out  8  captured byte; bit i = F sampled at addr = i.
- data_valid  out  1  high in HOLD; data_out stable while high.
- data_ready  in  1  consumer accepts when data_valid && data_ready.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; addr=3'b000; busy=0; data_valid=0; data_out=8'h00; settle and bit counters cleared.
- Reset overrides everything, including mid-scan and mid-handshake. A partial byte is discarded.
- States:
  - IDLE: addr=0.
    - start=1 → addr = 0 (DESCEND=0) or 7 (DESCEND=1); bit_cnt=0; busy=1.
    - Next state is WAIT with settle_cnt=SETTLE_CYC, or SAMP directly if SETTLE_CYC=0.
  - WAIT: settle_cnt decrements each cycle. It is checked before decrement; on 1 → SAMP. Length is exactly SETTLE_CYC cycles.
  - SAMP: one cycle; data_out[addr] <= f_in at the closing edge.
    - bit_cnt=7 → HOLD; addr unchanged.
    - Else addr ±1, bit_cnt+1, and re-enter WAIT (or SAMP if SETTLE_CYC=0).
  - HOLD: data_valid=1; addr holds the last value.
    - data_ready=1 → IDLE at that edge; data_valid=0 and busy=0 from the next cycle; addr returns to 0.
    - data_out retains its value until the next scan writes it.
- Each bit takes SETTLE_CYC+1 cycles. data_valid rises 8*(SETTLE_CYC+1) cycles after the start-accept edge: 16 cycles for the default.
- data_out bit i always corresponds to input i, independent of DESCEND.
- start while busy is ignored; there is no queuing.
- start and data_ready high together in HOLD: the handshake completes and the block goes to IDLE. The new start is NOT accepted that cycle and is seen the following cycle if it is still high.
- addr changes only at edges and never skips or repeats within a scan.
- f_in is assumed stable after settle. The block adds no synchroniser.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, SAMP, HOLD), the 3-bit address width constant, and the SETTLE_CYC maximum.
- One natural sub-module, scan_addr_gen: a loadable up/down 3-bit counter with terminal-count flag, driven by DESCEND.
- FSM, settle counter and capture register stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → addr=0, busy=0, data_valid=0, data_out=8'h00.
- Ascending scan, SETTLE_CYC=1: model selector with D=8'hA5, pulse start → addr visits 0..7, each held 2 cycles. data_valid rises 16 cycles after accept with data_out=8'hA5; with data_ready=1 it drops next cycle and busy=0.
- DESCEND=1, D=8'h3C, SETTLE_CYC=0 → addr sequence 7,6,…,0, one cycle each. data_valid after 8 cycles, data_out=8'h3C.
- Backpressure: D=8'h81, hold data_ready=0 for 20 cycles → data_valid stays 1, data_out=8'h81, addr holds the last value. Raise data_ready → single-cycle accept.
- start pulsed mid-scan and in HOLD together with data_ready → ignored; exactly one byte is produced per accepted start.
- rst asserted at bit 4 of a scan → next cycle addr=0, busy=0, data_out=8'h00. A fresh start then captures 8'hFF correctly.

Source files
------------

// File: rtl/mux_scan_capture_pkg.sv
// Shared types and constants for the mux scan/capture sequencer.
// State encoding, address width and settle-time limit.
package mux_scan_capture_pkg;

   localparam int unsigned ADDR_W     = 3;
   localparam int unsigned SETTLE_W   = 4;
   localparam int unsigned SETTLE_MAX = 15;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMP,
      S_HOLD
   } state_e;

endpackage

// File: rtl/mux_scan_capture_addr_gen.sv
// Loadable up/down 3-bit scan address counter.
// tc flags the last address of the scan in the chosen direction.
module scan_addr_gen
   import mux_scan_capture_pkg::*;
#(
   parameter bit DESCEND = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              tc
);

   localparam logic [ADDR_W-1:0] FIRST = DESCEND ? '1 : '0;
   localparam logic [ADDR_W-1:0] LAST  = DESCEND ? '0 : '1;

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   // Next address: clear wins over load, load over step.
   always_comb begin
      addr_d = addr_q;
      if (clr)
         addr_d = '0;
      else if (load)
         addr_d = FIRST;
      else if (step)
         addr_d = DESCEND ? addr_q - 1'b1 : addr_q + 1'b1;
   end

   // Address register.
   always_ff @(posedge clk) begin
      if (rst)
         addr_q <= '0;
      else
         addr_q <= addr_d;
   end

   assign addr = addr_q;
   assign tc   = (addr_q == LAST);

endmodule

// File: rtl/mux_scan_capture.sv
// Steps an 8:1 selector through all inputs, samples F after a settle
// time and hands the assembled byte out on a valid/ready port.
module mux_scan_capture
   import mux_scan_capture_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 1,
   parameter bit          DESCEND    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              f_in,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic [7:0]        data_out,
   output logic              data_valid,
   input  logic              data_ready
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC);
   localparam bit NO_SETTLE = (SETTLE_CYC == 0);

   state_e              state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [7:0]          data_q, data_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                a_clr, a_load, a_step, a_tc;

   // The address counter's terminal count marks the eighth bit.
   scan_addr_gen #(
      .DESCEND (DESCEND)
   ) u_addr (
      .clk  (clk),
      .rst  (rst),
      .clr  (a_clr),
      .load (a_load),
      .step (a_step),
      .addr (addr),
      .tc   (a_tc)
   );

   // Scan sequencing, settle countdown and bit capture.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      data_d   = data_q;
      a_clr    = 1'b0;
      a_load   = 1'b0;
      a_step   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_load   = 1'b1;
               settle_d = SETTLE_LD;
               state_d  = NO_SETTLE ? S_SAMP : S_WAIT;
            end
         end
         S_WAIT: begin
            settle_d = settle_q - 1'b1;
            if (settle_q <= 1)
               state_d = S_SAMP;
         end
         S_SAMP: begin
            data_d[addr] = f_in;
            if (a_tc) begin
               state_d = S_HOLD;
            end else begin
               a_step   = 1'b1;
               settle_d = SETTLE_LD;
               state_d  = NO_SETTLE ? S_SAMP : S_WAIT;
            end
         end
         S_HOLD: begin
            if (data_ready) begin
               a_clr   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_HOLD);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   assign busy       = busy_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;

endmodule
